// File: rtl/tl_ram_responder_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the TileLink-UH RAM responder.
// Holds the A/D channel opcode encodings, the responder FSM state type and
// small opcode classification helpers used by the responder.
package tl_ram_responder_pkg;

    // A-channel opcodes
    localparam logic [2:0] PUT_FULL = 3'd0;
    localparam logic [2:0] PUT_PART = 3'd1;
    localparam logic [2:0] ARITH    = 3'd2;
    localparam logic [2:0] LOGIC    = 3'd3;
    localparam logic [2:0] GET      = 3'd4;
    localparam logic [2:0] INTENT   = 3'd5;

    // D-channel opcodes
    localparam logic [2:0] ACK      = 3'd0;
    localparam logic [2:0] ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_RESP,
        S_WR_BURST,
        S_WR_ACK
    } state_e;

    // Opcodes this RAM actually serves; everything else is answered denied.
    function automatic logic opcode_legal(input logic [2:0] op);
        return (op == PUT_FULL) || (op == PUT_PART) || (op == GET);
    endfunction

    // Opcodes whose request carries a data payload (one A beat per data beat).
    // Payload-less opcodes follow the read path with a single A beat.
    function automatic logic has_payload(input logic [2:0] op);
        return (op == PUT_FULL) || (op == PUT_PART) || (op == ARITH) || (op == LOGIC);
    endfunction

endpackage

// File: rtl/tl_ram_responder_if.sv
`timescale 1ns/1ps
// TileLink A/D channel bundle plus the single-port SRAM port of the responder.
//   slave  : view of the responder (consumes A, produces D, drives the SRAM)
//   master : view of the environment (requester on A/D, SRAM model on mem_*)
interface tl_ram_responder_if #(
    parameter int AW   = 32,
    parameter int DW   = 64,
    parameter int SRCW = 4,
    parameter int SZW  = 3,
    parameter int MAW  = 10
) ();
    localparam int BPB = DW / 8;

    // A channel
    logic            a_valid;
    logic            a_ready;
    logic [2:0]      a_opcode;
    logic [2:0]      a_param;
    logic [SZW-1:0]  a_size;
    logic [SRCW-1:0] a_source;
    logic [AW-1:0]   a_address;
    logic [BPB-1:0]  a_mask;
    logic [DW-1:0]   a_data;

    // D channel
    logic            d_valid;
    logic            d_ready;
    logic [2:0]      d_opcode;
    logic [1:0]      d_param;
    logic [SZW-1:0]  d_size;
    logic [SRCW-1:0] d_source;
    logic            d_sink;
    logic            d_denied;
    logic            d_corrupt;
    logic [DW-1:0]   d_data;

    // SRAM port
    logic            mem_req;
    logic            mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [BPB-1:0]  mem_be;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
        input  d_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
        output d_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/tl_ram_responder.sv
`timescale 1ns/1ps
// TileLink-UH manager endpoint terminating Get / PutFullData / PutPartialData
// onto a single-port synchronous SRAM (read data valid the cycle after the
// request). One transaction in flight; single- and multi-beat bursts.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : slave view of the A/D channels and the SRAM port
module tl_ram_responder
    import tl_ram_responder_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            DW        = 64,
    parameter int            SRCW      = 4,
    parameter int            SZW       = 3,
    parameter int            MAX_SIZE  = 6,
    parameter logic [AW-1:0] ADDR_BASE = AW'(32'h8000_0000),
    parameter int            MEM_DEPTH = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    tl_ram_responder_if.slave bus
);

    localparam int          BPB       = DW / 8;
    localparam int          LOG2BPB   = $clog2(BPB);
    localparam int          MAW       = $clog2(MEM_DEPTH);
    localparam int          BCW       = (MAX_SIZE > LOG2BPB) ? (MAX_SIZE - LOG2BPB) : 1;
    localparam logic [AW:0] MEM_BYTES = (AW+1)'(MEM_DEPTH * BPB);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [2:0]      r_opcode;
    logic [SZW-1:0]  r_size;
    logic [SRCW-1:0] r_source;
    logic [MAW-1:0]  r_base_word;
    logic            r_denied;
    logic [BCW-1:0]  r_beat;
    logic [BCW-1:0]  r_beats_m1;
    logic [DW-1:0]   r_d_data;

    logic            w_a_fire;
    logic            w_d_fire;
    logic [AW-1:0]   w_offset;
    logic [AW:0]     w_bytes;
    logic [AW:0]     w_span_end;
    logic [AW:0]     w_align_mask;
    logic            w_aligned;
    logic            w_in_range;
    logic            w_denied;
    logic [BCW-1:0]  w_beats_m1;
    logic            w_last_beat;
    logic [MAW-1:0]  w_mem_addr_burst;
    logic            w_unused;

    assign w_a_fire = bus.a_valid && bus.a_ready;
    assign w_d_fire = bus.d_valid && bus.d_ready;

    // First-beat decode. The span end is one bit wider than the address so a
    // request touching the top of the address space cannot wrap into range.
    assign w_offset     = bus.a_address - ADDR_BASE;
    assign w_bytes      = (AW+1)'(1) << bus.a_size;
    assign w_span_end   = {1'b0, w_offset} + w_bytes;
    assign w_align_mask = w_bytes - (AW+1)'(1);
    assign w_aligned    = (bus.a_address & w_align_mask[AW-1:0]) == '0;
    assign w_in_range   = (bus.a_address >= ADDR_BASE) && (w_span_end <= MEM_BYTES);
    assign w_denied     = !opcode_legal(bus.a_opcode) || !w_aligned || !w_in_range;

    always_comb begin
        w_beats_m1 = '0;
        if (int'(bus.a_size) > LOG2BPB) begin
            w_beats_m1 = BCW'((1 << (int'(bus.a_size) - LOG2BPB)) - 1);
        end
    end

    assign w_last_beat      = (r_beat == r_beats_m1);
    assign w_mem_addr_burst = r_base_word + MAW'(r_beat);
    assign w_unused         = ^{bus.a_param, w_align_mask[AW]};

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        bus.a_ready   = 1'b0;
        bus.d_valid   = 1'b0;
        bus.d_opcode  = ACK;
        bus.d_param   = '0;
        bus.d_size    = '0;
        bus.d_source  = '0;
        bus.d_sink    = 1'b0;
        bus.d_denied  = 1'b0;
        bus.d_corrupt = 1'b0;
        bus.d_data    = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;

        // Reset forces every handshake and strobe low within the same cycle.
        if (!rst_i) begin
            case (r_state)
                S_IDLE: begin
                    bus.a_ready = 1'b1;
                    if (bus.a_valid) begin
                        if (has_payload(bus.a_opcode)) begin
                            // Beat 0 of a Put is written straight from the A channel.
                            if (!w_denied) begin
                                bus.mem_req   = 1'b1;
                                bus.mem_we    = 1'b1;
                                bus.mem_addr  = w_offset[LOG2BPB +: MAW];
                                bus.mem_be    = (bus.a_opcode == PUT_PART) ? bus.a_mask : '1;
                                bus.mem_wdata = bus.a_data;
                            end
                            w_state_nxt = (w_beats_m1 == '0) ? S_WR_ACK : S_WR_BURST;
                        end else begin
                            w_state_nxt = S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    bus.mem_req  = !r_denied;
                    bus.mem_addr = w_mem_addr_burst;
                    w_state_nxt  = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    w_state_nxt = S_RD_RESP;
                end
                S_RD_RESP: begin
                    bus.d_valid   = 1'b1;
                    bus.d_opcode  = ACK_DATA;
                    bus.d_size    = r_size;
                    bus.d_source  = r_source;
                    bus.d_denied  = r_denied;
                    bus.d_corrupt = r_denied;
                    bus.d_data    = r_d_data;
                    if (bus.d_ready) begin
                        w_state_nxt = w_last_beat ? S_IDLE : S_RD_REQ;
                    end
                end
                S_WR_BURST: begin
                    bus.a_ready = 1'b1;
                    if (bus.a_valid) begin
                        // Follow-on beats reuse the first beat's opcode and address.
                        if (!r_denied) begin
                            bus.mem_req   = 1'b1;
                            bus.mem_we    = 1'b1;
                            bus.mem_addr  = w_mem_addr_burst;
                            bus.mem_be    = (r_opcode == PUT_PART) ? bus.a_mask : '1;
                            bus.mem_wdata = bus.a_data;
                        end
                        if (w_last_beat) begin
                            w_state_nxt = S_WR_ACK;
                        end
                    end
                end
                S_WR_ACK: begin
                    bus.d_valid  = 1'b1;
                    bus.d_opcode = ACK;
                    bus.d_size   = r_size;
                    bus.d_source = r_source;
                    bus.d_denied = r_denied;
                    if (bus.d_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_opcode    <= '0;
            r_size      <= '0;
            r_source    <= '0;
            r_base_word <= '0;
            r_denied    <= 1'b0;
            r_beat      <= '0;
            r_beats_m1  <= '0;
            r_d_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_a_fire) begin
                        r_opcode    <= bus.a_opcode;
                        r_size      <= bus.a_size;
                        r_source    <= bus.a_source;
                        r_base_word <= w_offset[LOG2BPB +: MAW];
                        r_denied    <= w_denied;
                        r_beats_m1  <= w_beats_m1;
                        // A Put consumed beat 0 already; a read starts at beat 0.
                        r_beat      <= has_payload(bus.a_opcode) ? BCW'(1) : '0;
                    end
                end
                S_RD_WAIT: begin
                    r_d_data <= r_denied ? '0 : bus.mem_rdata;
                end
                S_RD_RESP: begin
                    if (w_d_fire) begin
                        r_beat <= w_last_beat ? '0 : r_beat + BCW'(1);
                    end
                end
                S_WR_BURST: begin
                    if (w_a_fire) begin
                        r_beat <= w_last_beat ? '0 : r_beat + BCW'(1);
                    end
                end
                S_WR_ACK: begin
                    if (w_d_fire) begin
                        r_beat <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Requests larger than MAX_SIZE have no defined response.
    a_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        w_a_fire |-> (int'(bus.a_size) <= MAX_SIZE));

endmodule

// File: doc/tl_ram_responder.md
Name: tl_ram_responder

Overview:
- TileLink-UH responder (manager end of TL_BUS A/D channels); terminates Get/PutFullData/PutPartialData onto a single-port synchronous SRAM.
- Sits behind the TL crossbar/connectors as the leaf device for on-chip scratchpad/boot RAM.
- Returns AccessAck/AccessAckData on D. Single-beat and multi-beat bursts; one transaction in flight.

Parameters:
- AW, 32, TL address width
- DW, 64, TL data width (bits); BPB = DW/8 bytes per beat
- SRCW, 4, a_source/d_source width
- SZW, 3, a_size/d_size width
- MAX_SIZE, 6, largest legal log2(bytes) (64 B = 8 beats at DW=64)
- ADDR_BASE, 32'h8000_0000, first byte address served
- MEM_DEPTH, 1024, SRAM words of DW bits; MAW = clog2(MEM_DEPTH)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- a_valid/a_ready  in/out  1  A handshake
- a_opcode  in  3  A opcode
- a_param  in  3  ignored
- a_size  in  SZW  log2 bytes
- a_source  in  SRCW  requester id
- a_address  in  AW  byte address
- a_mask  in  BPB  byte lanes
- a_data  in  DW  write data
- d_valid/d_ready  out/in  1  D handshake
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  SZW  echo of a_size
- d_source  out  SRCW  echo of a_source
- d_sink  out  1  always 0
- d_denied  out  1  error response
- d_corrupt  out  1  data invalid
- d_data  out  DW  read data
- mem_req  out  1  SRAM access strobe
- mem_we  out  1  1=write
- mem_addr  out  MAW  word address
- mem_be  out  BPB  byte enables
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid cycle after mem_req&&!mem_we

Behaviour:
- Reset: state=IDLE, a_ready=0 during rst_i then 1 in IDLE, d_valid=0, mem_req=0, mem_we=0, beat counter=0, all D fields 0.
- beats = (a_size <= log2(BPB)) ? 1 : 2^a_size/BPB. a_size>MAX_SIZE is a protocol violation (assertion, no defined response).
- Denied if: opcode not in {0,1,4}; address not aligned to 2^a_size; any byte of [addr, addr+2^a_size) outside [ADDR_BASE, ADDR_BASE+MEM_DEPTH*BPB). Decided on first beat, held for the burst.
- mem_addr = (addr - ADDR_BASE)>>log2(BPB) + beat index. mem_be = a_mask (PutPartial), all ones (PutFull).
- States: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_BURST, WR_ACK.
- IDLE (a_ready=1): on A fire latch opcode/size/source/address/denied. Get -> RD_REQ. Put: if !denied, write beat 0 in the same cycle (mem_req=mem_we=1, combinational from A fire); beats==1 -> WR_ACK else WR_BURST.
- RD_REQ: mem_req=1, mem_we=0 (suppressed if denied) -> RD_WAIT.
- RD_WAIT: capture mem_rdata into d_data register (0 if denied) -> RD_RESP.
- RD_RESP: d_valid=1, d_opcode=1, d_denied=d_corrupt=denied. D fields stable until d_ready. On fire: last beat -> IDLE, else beat+1 -> RD_REQ. One beat per 3 cycles minimum.
- WR_BURST: a_ready=1; each fire writes (unless denied) at base+beat. Last beat -> WR_ACK. Later beats' opcode/size/address are not re-checked.
- WR_ACK: a_ready=0, d_valid=1, d_opcode=0, d_denied=denied, d_corrupt=0, d_data=0. d_ready -> IDLE.
- a_ready=0 in all RD_* and WR_ACK states; no A beat accepted while a D response is pending.
- d_valid never drops before d_ready. d_ready held low stalls indefinitely with no SRAM re-access.
- Back-to-back: A can fire the cycle after D fire of previous transaction (IDLE re-entered).
- rst_i mid-burst: abort immediately to reset values. Partial writes already issued remain in SRAM.

Decomposition:
- tl_pkg (shared): A/D opcode localparams (PUT_FULL=0, PUT_PART=1, ARITH=2, LOGIC=3, GET=4, INTENT=5; ACK=0, ACK_DATA=1), state enum type.
- No sub-module; SRAM model lives in the bench. Optional TL_BUS-port wrapper instantiates this block.

Test Plan:
- Single Get 8 B at 0x8000_0010 with SRAM word 2=0x1122334455667788 -> mem_req addr 2; d_opcode=1, d_data=0x1122334455667788, d_source echoed, denied=0.
- PutPartial addr 0x8000_0008 mask 0x0F data 0xAAAA_BBBB_CCCC_DDDD -> mem_we addr 1 be 0x0F; one AccessAck, denied=0; next Get returns low 4 bytes updated only.
- PutFull 64 B burst at 0x8000_0040, 8 beats, then 8-beat Get -> writes at words 8..15, single ack after beat 8; Get returns same 8 words in order.
- Get at 0x8000_0004 size 3 (misaligned) and Get at ADDR_BASE+MEM_DEPTH*8 -> no mem_req; d_denied=1, d_corrupt=1, d_data=0.
- Arithmetic opcode 2, size 4 (2 beats) -> both beats accepted, no writes; one AccessAck denied=1.
- Hold d_ready=0 20 cycles during 4-beat Get, then assert rst_i mid-burst -> D fields stable and no extra mem_req while stalled; after reset d_valid=0, a_ready=1, next Get served normally.
